// File: rtl/cache_pkg.sv
// Shared types and block geometry for the cache block-fill controller.
package cache_pkg;

   localparam int WORDS_PER_BLOCK   = 8;
   localparam int BLOCK_OFFSET_BITS = 4;
   localparam int CNT_W             = 4;
   localparam int FILL_DATA_W       = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      TAG_WR = 2'd2
   } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss/fill bus between the cache pipeline, main memory and the fill controller.
interface cache_fill_fsm_if #(
   parameter int ADDR_WIDTH = 16
);
   import cache_pkg::*;

   logic                   miss_detected;
   logic [ADDR_WIDTH-1:0]  miss_address;
   logic                   fsm_busy;
   logic                   write_data_array;
   logic                   write_tag_array;
   logic [2:0]             word_num;
   logic [ADDR_WIDTH-1:0]  memory_address;
   logic                   memory_read_enable;
   logic                   memory_data_valid;
   logic [FILL_DATA_W-1:0] memory_data_in;
   logic [FILL_DATA_W-1:0] fill_data;

   modport master (
      input  miss_detected, miss_address, memory_data_valid, memory_data_in,
      output fsm_busy, write_data_array, write_tag_array, word_num,
             memory_address, memory_read_enable, fill_data
   );

   modport slave (
      output miss_detected, miss_address, memory_data_valid, memory_data_in,
      input  fsm_busy, write_data_array, write_tag_array, word_num,
             memory_address, memory_read_enable, fill_data
   );

endinterface

// File: rtl/cache_fill_counter.sv
// Saturating 4-bit event counter with synchronous clear and a done flag.
module cache_fill_counter
   import cache_pkg::*;
#(
   parameter int DONE_AT = WORDS_PER_BLOCK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o,
   output logic             done_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign done_o  = (count_q == CNT_W'(DONE_AT));
   assign count_o = count_q;

   // Holding at DONE_AT keeps a stray enable from wrapping back into range.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && !done_o) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// Block-fill controller: on a miss, streams one block of words from memory
// into the data array, then writes the tag/valid entry.
module cache_fill_fsm #(
   parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
   parameter int ADDR_WIDTH      = 16
) (
   input  logic             clk,
   input  logic             rst,
   cache_fill_fsm_if.master bus
);
   import cache_pkg::*;

   localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(WORDS_PER_BLOCK - 1);
   localparam logic [CNT_W-1:0] ALL_ISSUED = CNT_W'(WORDS_PER_BLOCK);

   fill_state_e           state_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic                  mem_rd_q;
   logic                  tag_wr_q;

   logic [CNT_W-1:0]      issue_cnt;
   logic [CNT_W-1:0]      rx_cnt;
   logic [CNT_W-1:0]      issue_nxt;
   logic                  issue_done;
   logic                  rx_done;
   logic                  in_fill;
   logic                  issue_take;
   logic                  data_take;
   logic [ADDR_WIDTH-1:0] miss_base;

   assign in_fill    = (state_q == FILL);
   assign issue_take = in_fill && mem_rd_q && !issue_done;
   assign data_take  = in_fill && bus.memory_data_valid && !rx_done;
   assign issue_nxt  = issue_cnt + 1'b1;
   assign miss_base  = {bus.miss_address[ADDR_WIDTH-1:BLOCK_OFFSET_BITS],
                        {BLOCK_OFFSET_BITS{1'b0}}};

   cache_fill_counter #(.DONE_AT(WORDS_PER_BLOCK)) u_issue_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (!in_fill),
      .en_i    (issue_take),
      .count_o (issue_cnt),
      .done_o  (issue_done)
   );

   cache_fill_counter #(.DONE_AT(WORDS_PER_BLOCK)) u_rx_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (!in_fill),
      .en_i    (data_take),
      .count_o (rx_cnt),
      .done_o  (rx_done)
   );

   // Request address is precomputed one cycle ahead so the read port is registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         tag_wr_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.miss_detected) begin
                  state_q    <= FILL;
                  base_q     <= miss_base;
                  mem_addr_q <= miss_base;
                  mem_rd_q   <= 1'b1;
               end
            end
            FILL: begin
               if (issue_take) begin
                  if (issue_nxt == ALL_ISSUED) begin
                     mem_rd_q   <= 1'b0;
                     mem_addr_q <= '0;
                  end else begin
                     mem_addr_q <= base_q | ADDR_WIDTH'({issue_nxt, 1'b0});
                  end
               end
               if (data_take && rx_cnt == LAST_WORD) begin
                  state_q    <= TAG_WR;
                  tag_wr_q   <= 1'b1;
                  mem_rd_q   <= 1'b0;
                  mem_addr_q <= '0;
               end
            end
            TAG_WR: begin
               state_q  <= IDLE;
               tag_wr_q <= 1'b0;
            end
            default: begin
               state_q  <= IDLE;
               tag_wr_q <= 1'b0;
               mem_rd_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fsm_busy           = (state_q != IDLE);
   assign bus.write_data_array   = data_take;
   assign bus.write_tag_array    = tag_wr_q;
   assign bus.word_num           = rx_cnt[2:0];
   assign bus.memory_address     = mem_addr_q;
   assign bus.memory_read_enable = mem_rd_q;
   assign bus.fill_data          = bus.memory_data_in;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized bench for cache_fill_fsm against a cycle-level behavioural model
// and a latency-programmable memory responder.
module tb_cache_fill_fsm;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_fill_fsm_if #(.ADDR_WIDTH(16)) bus ();

   cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // model: phase 0 idle, 1 fetching block, 2 tag write
   int m_phase  = 0;
   int m_base   = 0;
   int m_issued = 0;
   int m_rx     = 0;

   typedef struct {
      int addr;
      int rdy;
   } req_t;
   req_t mq[$];

   int lat       = 4;
   int gap_mode  = 0;
   int spur_mode = 0;
   bit lat_chk   = 0;
   bit saw_req   = 1;
   int acc_cyc   = 0;
   bit hit_abc0  = 0;
   bit cur_miss  = 0;
   int cur_maddr = 0;
   bit cur_vld   = 0;
   bit obs_mre   = 0;
   int obs_addr  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] mem_word(input int a);
      return 16'((a * 40503) ^ 23055);
   endfunction

   task automatic drive(input bit miss, input int maddr);
      bit gap;
      case (gap_mode)
         1:       gap = (cyc % 2) == 1;
         2:       gap = $urandom_range(99) < 35;
         default: gap = 1'b0;
      endcase
      bus.miss_detected     = miss;
      bus.miss_address      = 16'(maddr);
      bus.memory_data_valid = 1'b0;
      bus.memory_data_in    = 16'($urandom);
      if (mq.size() > 0 && mq[0].rdy <= cyc && !gap) begin
         bus.memory_data_valid = 1'b1;
         bus.memory_data_in    = mem_word(mq[0].addr);
         void'(mq.pop_front());
      end else if (m_phase != 1 && (spur_mode == 2 || (spur_mode == 1 && $urandom_range(3) == 0))) begin
         bus.memory_data_valid = 1'b1;
      end
      cur_miss  = miss;
      cur_maddr = maddr;
      cur_vld   = bus.memory_data_valid;
   endtask

   task automatic check_outputs();
      bit e_mre;
      bit e_wda;
      e_mre = (m_phase == 1) && (m_issued < 8);
      e_wda = (m_phase == 1) && cur_vld;
      check("busy", 32'(bus.fsm_busy), 32'(m_phase != 0));
      check("rd_en", 32'(bus.memory_read_enable), 32'(e_mre));
      if (e_mre) check("rd_addr", 32'(bus.memory_address), m_base + 2 * m_issued);
      check("wr_data", 32'(bus.write_data_array), 32'(e_wda));
      if (e_wda) begin
         check("word_num", 32'(bus.word_num), m_rx);
         check("fill_data", 32'(bus.fill_data), 32'(mem_word(m_base + 2 * m_rx)));
      end
      check("wr_tag", 32'(bus.write_tag_array), 32'(m_phase == 2));
      if (lat_chk && bus.memory_read_enable === 1'b1 && !saw_req) begin
         saw_req = 1'b1;
         check("first_req_latency", cyc - acc_cyc, 1);
      end
      if (lat_chk && bus.write_tag_array === 1'b1)
         check("tag_latency", cyc - acc_cyc, 9 + lat);
      if (bus.memory_read_enable === 1'b1 && bus.memory_address === 16'hABC0) hit_abc0 = 1'b1;
      obs_mre  = (bus.memory_read_enable === 1'b1);
      obs_addr = 32'(bus.memory_address);
   endtask

   task automatic update_model();
      if (obs_mre) mq.push_back('{addr: obs_addr, rdy: cyc + lat});
      case (m_phase)
         0: if (cur_miss) begin
            m_phase  = 1;
            m_base   = cur_maddr & 32'hFFF0;
            m_issued = 0;
            m_rx     = 0;
            acc_cyc  = cyc;
            saw_req  = 1'b0;
         end
         1: begin
            if (m_issued < 8) m_issued++;
            if (cur_vld) begin
               m_rx++;
               if (m_rx == 8) m_phase = 2;
            end
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic step(input bit miss, input int maddr);
      drive(miss, maddr);
      #2;
      check_outputs();
      @(posedge clk);
      update_model();
      cyc++;
      #1;
   endtask

   task automatic run_idle(input int max);
      int n = 0;
      do begin
         step(1'b0, 0);
         n++;
      end while ((m_phase != 0 || mq.size() != 0) && n < max);
      check("fill_completes", 32'(m_phase != 0 || mq.size() != 0), 0);
   endtask

   task automatic check_reset_zero(input string pfx);
      check({pfx, "_busy"},   32'(bus.fsm_busy), 0);
      check({pfx, "_wr_data"}, 32'(bus.write_data_array), 0);
      check({pfx, "_wr_tag"}, 32'(bus.write_tag_array), 0);
      check({pfx, "_rd_en"},  32'(bus.memory_read_enable), 0);
      check({pfx, "_word"},   32'(bus.word_num), 0);
      check({pfx, "_addr"},   32'(bus.memory_address), 0);
   endtask

   task automatic apply_reset(input int cycles);
      bus.miss_detected     = 1'b0;
      bus.memory_data_valid = 1'b1;
      rst = 1'b0;
      #1;
      check_reset_zero("rst_mid");
      m_phase = 0;
      mq.delete();
      repeat (cycles) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      check_reset_zero("rst_hold");
      bus.memory_data_valid = 1'b0;
      rst = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst                   = 1'b0;
      bus.miss_detected     = 1'b0;
      bus.miss_address      = '0;
      bus.memory_data_valid = 1'b1;
      bus.memory_data_in    = '0;
      #1;
      check_reset_zero("por");
      repeat (2) @(posedge clk);
      #1;
      bus.memory_data_valid = 1'b0;
      rst = 1'b1;

      // basic fill, fixed latency 4, cycle-exact timing
      lat = 4; gap_mode = 0; spur_mode = 0; lat_chk = 1'b1;
      step(1'b1, 'h1236);
      run_idle(40);
      lat_chk = 1'b0;

      // stalled memory: latency 1, valid dropped on alternate cycles
      lat = 1; gap_mode = 1;
      step(1'b1, 'h4A7C);
      run_idle(60);

      // misses while busy must be ignored
      lat = 3; gap_mode = 0; hit_abc0 = 1'b0;
      step(1'b1, 'h2220);
      repeat (6) step(1'b1, 'hABC0);
      run_idle(40);
      check("busy_miss_addr", 32'(hit_abc0), 0);

      // reset after three words, then a fresh fill from word 0
      lat = 2;
      step(1'b1, 'h7000);
      n = 0;
      while (m_rx < 3 && n < 30) begin
         step(1'b0, 0);
         n++;
      end
      check("rx_before_reset", m_rx, 3);
      apply_reset(2);
      step(1'b1, 'h7010);
      run_idle(40);

      // spurious valid while idle
      spur_mode = 2;
      repeat (6) step(1'b0, 0);
      spur_mode = 0;

      // top-of-address-space block
      lat = 2;
      step(1'b1, 'hFFFE);
      run_idle(40);

      // randomized traffic
      spur_mode = 1;
      repeat (40) begin
         lat      = $urandom_range(1, 6);
         gap_mode = $urandom_range(0, 2);
         repeat ($urandom_range(20, 60)) step($urandom_range(0, 3) == 0, int'($urandom));
      end
      spur_mode = 0;
      run_idle(200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
